// File: rtl/trace_pkg.sv
// Shared types for the retire-trace checker: golden record layout, kind
// encodings, the retire event carried through the buffer, and FSM states.
package trace_pkg;

   // Golden record: {pc, instr, data, mem_addr, rd, kind, load}, MSB first.
   localparam int REC_W         = 136;
   localparam int REC_PC_LSB    = 104;
   localparam int REC_INSTR_LSB = 72;
   localparam int REC_DATA_LSB  = 40;
   localparam int REC_MADDR_LSB = 8;
   localparam int REC_RD_LSB    = 3;
   localparam int REC_KIND_LSB  = 1;
   localparam int REC_LOAD_BIT  = 0;

   typedef enum logic [1:0] {
      KIND_NONE  = 2'd0,
      KIND_INT   = 2'd1,
      KIND_FLOAT = 2'd2,
      KIND_STORE = 2'd3
   } kind_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  rd;
      logic [31:0] data;
      logic [31:0] mem_addr;
      logic [31:0] mem_data;
      logic        is_load;
      logic        is_store;
      logic        is_float;
   } trace_event_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] data;
      logic [31:0] mem_addr;
      logic [4:0]  rd;
      kind_t       kind;
      logic        load;
   } golden_rec_t;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_CMP   = 3'd2,
      S_DONE  = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   function automatic golden_rec_t unpack_rec(input logic [REC_W-1:0] raw);
      golden_rec_t r;
      r.pc       = raw[REC_PC_LSB +: 32];
      r.instr    = raw[REC_INSTR_LSB +: 32];
      r.data     = raw[REC_DATA_LSB +: 32];
      r.mem_addr = raw[REC_MADDR_LSB +: 32];
      r.rd       = raw[REC_RD_LSB +: 5];
      r.kind     = kind_t'(raw[REC_KIND_LSB +: 2]);
      r.load     = raw[REC_LOAD_BIT];
      return r;
   endfunction

   // True when a retired event agrees with its golden record.
   function automatic logic rec_matches(input golden_rec_t rec, input trace_event_t ev);
      logic ok;
      ok = (ev.pc == rec.pc) && (ev.instr == rec.instr) &&
           (ev.is_load == rec.load) && (ev.is_store == (rec.kind == KIND_STORE));
      case (rec.kind)
         KIND_STORE: ok = ok && (ev.mem_addr == rec.mem_addr) && (ev.mem_data == rec.data);
         KIND_INT, KIND_FLOAT: begin
            ok = ok && (ev.rd == rec.rd) && (ev.data == rec.data) &&
                 (ev.is_float == (rec.kind == KIND_FLOAT));
            if (rec.load) ok = ok && (ev.mem_addr == rec.mem_addr);
         end
         // No architectural write expected: an integer write is only
         // harmless when it targets x0.
         default: ok = ok && (ev.is_float || (ev.rd == 5'd0));
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word fall-through retire-event buffer. A push into a full buffer is
// accepted only when a pop happens in the same cycle.
module trace_fifo
   import trace_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic         clk_i,
   input  logic         reset_i,
   input  logic         push_i,
   input  trace_event_t data_i,
   input  logic         pop_i,
   output trace_event_t head_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   trace_event_t   mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [CW-1:0]  count;
   logic           do_push;
   logic           do_pop;

   assign full_o  = (count == CW'(DEPTH));
   assign empty_o = (count == '0);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign head_o  = mem[rd_ptr];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= data_i;
   end

endmodule

// File: rtl/trace_checker.sv
// Retire-trace checker: buffers retired instructions and compares each one
// against a golden record fetched over a request/acknowledge port.
//
// Golden read handshake: exp_req_o rises on entering FETCH and stays high,
// with exp_idx_o stable, until a cycle in which exp_ack_i is high. That cycle
// transfers exp_rec_i and the request drops on the next cycle. exp_ack_i is
// ignored whenever no request is outstanding. Retire events have no
// back-pressure: an event offered to a full buffer with no pop is dropped.
module trace_checker
   import trace_pkg::*;
#(
   parameter int FIFO_DEPTH       = 8,
   parameter int TRACE_LEN        = 1024,
   parameter int STOP_ON_MISMATCH = 1
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         valid_i,
   input  logic [31:0]                  pc_i,
   input  logic [31:0]                  instr_i,
   input  logic [4:0]                   reg_addr_i,
   input  logic [31:0]                  reg_data_i,
   input  logic                         is_load_i,
   input  logic                         is_store_i,
   input  logic                         is_float_i,
   input  logic [31:0]                  mem_addr_i,
   input  logic [31:0]                  mem_data_i,
   output logic                         exp_req_o,
   output logic [$clog2(TRACE_LEN)-1:0] exp_idx_o,
   input  logic                         exp_ack_i,
   input  logic [REC_W-1:0]             exp_rec_i,
   output logic [31:0]                  match_cnt_o,
   output logic                         done_o,
   output logic                         mismatch_o,
   output logic                         overflow_o,
   output logic                         extra_o,
   output logic [$clog2(TRACE_LEN)-1:0] fail_idx_o,
   output logic [31:0]                  fail_pc_o,
   output state_t                       state_o
);

   localparam int IDX_W = $clog2(TRACE_LEN);

   state_t        state_q;
   state_t        state_d;
   logic [IDX_W-1:0] idx_q;
   golden_rec_t   rec_q;
   trace_event_t  push_ev;
   trace_event_t  head;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_pop;
   logic          do_cmp;
   logic          hit;
   logic          last;

   assign push_ev = '{pc: pc_i, instr: instr_i, rd: reg_addr_i, data: reg_data_i,
                      mem_addr: mem_addr_i, mem_data: mem_data_i, is_load: is_load_i,
                      is_store: is_store_i, is_float: is_float_i};

   trace_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push_i  (valid_i),
      .data_i  (push_ev),
      .pop_i   (fifo_pop),
      .head_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign hit       = rec_matches(rec_q, head);
   assign last      = (idx_q == IDX_W'(TRACE_LEN - 1));
   assign exp_req_o = (state_q == S_FETCH);
   assign exp_idx_o = idx_q;
   assign done_o    = (state_q == S_DONE);
   assign state_o   = state_q;

   // State register.
   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next-state and control. IDLE never holds a finished trace because the
   // last check goes straight to DONE, so non-empty is enough to fetch.
   always_comb begin
      state_d  = state_q;
      fifo_pop = 1'b0;
      do_cmp   = 1'b0;
      case (state_q)
         S_IDLE:  if (!fifo_empty) state_d = S_FETCH;
         S_FETCH: if (exp_ack_i) state_d = S_CMP;
         S_CMP: begin
            fifo_pop = 1'b1;
            do_cmp   = 1'b1;
            if (last)                                state_d = S_DONE;
            else if (!hit && STOP_ON_MISMATCH != 0)  state_d = S_HALT;
            else                                     state_d = S_IDLE;
         end
         S_DONE, S_HALT: fifo_pop = !fifo_empty;
         default: state_d = S_IDLE;
      endcase
   end

   // Record capture, check index, counters and sticky status flags.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         idx_q       <= '0;
         rec_q       <= '0;
         match_cnt_o <= '0;
         mismatch_o  <= 1'b0;
         overflow_o  <= 1'b0;
         extra_o     <= 1'b0;
         fail_idx_o  <= '0;
         fail_pc_o   <= '0;
      end else begin
         if (state_q == S_FETCH && exp_ack_i) rec_q <= unpack_rec(exp_rec_i);
         if (do_cmp) begin
            idx_q <= idx_q + IDX_W'(1);
            if (hit) begin
               if (match_cnt_o != 32'hFFFF_FFFF) match_cnt_o <= match_cnt_o + 32'd1;
            end else if (!mismatch_o) begin
               mismatch_o <= 1'b1;
               fail_idx_o <= idx_q;
               fail_pc_o  <= head.pc;
            end
         end
         if (valid_i && fifo_full && !fifo_pop) overflow_o <= 1'b1;
         if (state_q == S_DONE && valid_i)      extra_o    <= 1'b1;
      end
   end

endmodule

// File: tb/tb_trace_checker.sv
// Bench for trace_checker: two instances (long trace and a 4-record trace)
// share the retire inputs; each has its own golden-record responder.
module tb_trace_checker;
   import trace_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic        valid = 1'b0;
   logic [31:0] pc = '0, instr = '0, reg_data = '0, mem_addr = '0, mem_data = '0;
   logic [4:0]  reg_addr = '0;
   logic        is_load = 1'b0, is_store = 1'b0, is_float = 1'b0;

   logic             req_a, ack_a, done_a, mis_a, ovf_a, extra_a;
   logic [5:0]       idx_a, fidx_a;
   logic [REC_W-1:0] rec_a;
   logic [31:0]      match_a, fpc_a;
   state_t           state_a;

   logic             req_b, ack_b, done_b, mis_b, ovf_b, extra_b;
   logic [1:0]       idx_b, fidx_b;
   logic [REC_W-1:0] rec_b;
   logic [31:0]      match_b, fpc_b;
   state_t           state_b;

   int checks = 0;
   int errors = 0;
   int ack_delay = 0;
   logic [REC_W-1:0] golden [64];
   trace_event_t     evs [64];

   trace_checker #(.FIFO_DEPTH(8), .TRACE_LEN(64), .STOP_ON_MISMATCH(1)) dut_a (
      .clk_i(clk), .reset_i(reset), .valid_i(valid), .pc_i(pc), .instr_i(instr),
      .reg_addr_i(reg_addr), .reg_data_i(reg_data), .is_load_i(is_load),
      .is_store_i(is_store), .is_float_i(is_float), .mem_addr_i(mem_addr),
      .mem_data_i(mem_data), .exp_req_o(req_a), .exp_idx_o(idx_a), .exp_ack_i(ack_a),
      .exp_rec_i(rec_a), .match_cnt_o(match_a), .done_o(done_a), .mismatch_o(mis_a),
      .overflow_o(ovf_a), .extra_o(extra_a), .fail_idx_o(fidx_a), .fail_pc_o(fpc_a),
      .state_o(state_a));

   trace_checker #(.FIFO_DEPTH(8), .TRACE_LEN(4), .STOP_ON_MISMATCH(1)) dut_b (
      .clk_i(clk), .reset_i(reset), .valid_i(valid), .pc_i(pc), .instr_i(instr),
      .reg_addr_i(reg_addr), .reg_data_i(reg_data), .is_load_i(is_load),
      .is_store_i(is_store), .is_float_i(is_float), .mem_addr_i(mem_addr),
      .mem_data_i(mem_data), .exp_req_o(req_b), .exp_idx_o(idx_b), .exp_ack_i(ack_b),
      .exp_rec_i(rec_b), .match_cnt_o(match_b), .done_o(done_b), .mismatch_o(mis_b),
      .overflow_o(ovf_b), .extra_o(extra_b), .fail_idx_o(fidx_b), .fail_pc_o(fpc_b),
      .state_o(state_b));

   // Golden memory responders: acknowledge ack_delay cycles after a request.
   initial begin
      int cnt = 0;
      ack_a = 1'b0; rec_a = '0;
      forever begin
         @(negedge clk);
         if (reset || !req_a || ack_a) begin ack_a = 1'b0; cnt = 0; end
         else if (cnt >= ack_delay) begin ack_a = 1'b1; rec_a = golden[idx_a]; end
         else cnt++;
      end
   end

   initial begin
      int cnt = 0;
      ack_b = 1'b0; rec_b = '0;
      forever begin
         @(negedge clk);
         if (reset || !req_b || ack_b) begin ack_b = 1'b0; cnt = 0; end
         else if (cnt >= ack_delay) begin ack_b = 1'b1; rec_b = golden[idx_b]; end
         else cnt++;
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [REC_W-1:0] pack_rec(input logic [31:0] r_pc, r_instr, r_data,
         r_maddr, input logic [4:0] r_rd, input logic [1:0] r_kind, input logic r_load);
      return {r_pc, r_instr, r_data, r_maddr, r_rd, r_kind, r_load};
   endfunction

   // cls: 0 = no write (x0 int write), 1 = int, 2 = float, 3 = store.
   function automatic trace_event_t rand_event(input int cls);
      trace_event_t ev;
      ev.pc = $urandom; ev.instr = $urandom; ev.rd = 5'($urandom_range(1, 31));
      ev.data = $urandom; ev.mem_addr = $urandom; ev.mem_data = $urandom;
      ev.is_load = 1'($urandom_range(0, 1)); ev.is_store = 1'b0; ev.is_float = 1'b0;
      case (cls)
         0: ev.rd = 5'd0;
         2: ev.is_float = 1'b1;
         3: begin ev.is_store = 1'b1; ev.is_load = 1'b0; end
         default: ;
      endcase
      return ev;
   endfunction

   // Golden record that an honest core would produce for ev; fields the
   // checker must ignore are filled with noise.
   function automatic logic [REC_W-1:0] make_rec(input trace_event_t ev, input int cls);
      logic [31:0] d, ma;
      logic [4:0]  r;
      d  = (cls == 3) ? ev.mem_data : ((cls == 0) ? 32'($urandom) : ev.data);
      ma = (cls == 3 || ev.is_load) ? ev.mem_addr : 32'($urandom);
      r  = (cls == 0) ? 5'($urandom) : ev.rd;
      return pack_rec(ev.pc, ev.instr, d, ma, r, 2'(cls), ev.is_load);
   endfunction

   function automatic logic ref_match(input logic [REC_W-1:0] rec, input trace_event_t ev);
      logic [31:0] g_pc, g_instr, g_data, g_maddr;
      logic [4:0]  g_rd;
      logic [1:0]  g_kind;
      logic        g_load, ok;
      {g_pc, g_instr, g_data, g_maddr, g_rd, g_kind, g_load} = rec;
      ok = (ev.pc == g_pc) && (ev.instr == g_instr) && (ev.is_load == g_load)
           && (ev.is_store == (g_kind == 2'd3));
      if (g_kind == 2'd3)      ok = ok && ev.mem_addr == g_maddr && ev.mem_data == g_data;
      else if (g_kind == 2'd0) ok = ok && (ev.is_float || ev.rd == 5'd0);
      else ok = ok && (ev.is_float == (g_kind == 2'd2)) && ev.rd == g_rd
                && ev.data == g_data && (!g_load || ev.mem_addr == g_maddr);
      return ok;
   endfunction

   // ---------------- drivers ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic put_event(input trace_event_t ev);
      valid = 1'b1; pc = ev.pc; instr = ev.instr; reg_addr = ev.rd; reg_data = ev.data;
      mem_addr = ev.mem_addr; mem_data = ev.mem_data; is_load = ev.is_load;
      is_store = ev.is_store; is_float = ev.is_float;
   endtask

   task automatic send_event(input trace_event_t ev);
      put_event(ev);
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1; valid = 1'b0; ack_delay = 0;
      tick(2);
      reset = 1'b0;
      tick(1);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; valid = 1'b0;
      tick(2);
      checks++;
      if ({req_a, mis_a, ovf_a, extra_a, done_a, match_a, fidx_a, fpc_a} !== '0) begin
         errors++;
         $display("FAIL reset_outputs_a: got req=%b mis=%b ovf=%b extra=%b done=%b cnt=%0d, required all zero",
                  req_a, mis_a, ovf_a, extra_a, done_a, match_a);
      end
      checks++;
      if ({req_b, mis_b, ovf_b, extra_b, done_b, match_b, fidx_b, fpc_b} !== '0) begin
         errors++;
         $display("FAIL reset_outputs_b: got req=%b done=%b cnt=%0d, required all zero",
                  req_b, done_b, match_b);
      end
      checks++;
      if (state_a !== S_IDLE) begin
         errors++;
         $display("FAIL reset_state: got %0d, required %0d", state_a, S_IDLE);
      end
      reset = 1'b0;
      tick(1);
   endtask

   task automatic test_basic_match();
      int cls [3];
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cls[i] = $urandom_range(0, 3);
         evs[i] = rand_event(cls[i]);
         golden[i] = make_rec(evs[i], cls[i]);
      end
      send_event(evs[0]);
      tick(2);
      checks++;
      if (match_a !== 32'd0) begin
         errors++;
         $display("FAIL latency_early: got match_cnt=%0d, required 0", match_a);
      end
      tick(1);
      checks++;
      if (match_a !== 32'd1) begin
         errors++;
         $display("FAIL latency_3cyc: got match_cnt=%0d, required 1", match_a);
      end
      tick(4);
      for (int i = 1; i < 3; i++) begin
         send_event(evs[i]);
         tick(6);
      end
      checks++;
      if (match_a !== 32'd3 || mis_a !== 1'b0) begin
         errors++;
         $display("FAIL basic_match: got cnt=%0d mis=%b, required cnt=3 mis=0", match_a, mis_a);
      end
   endtask

   task automatic test_data_mismatch();
      logic saw_req = 1'b0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         evs[i] = rand_event(1);
         golden[i] = make_rec(evs[i], 1);
      end
      evs[2].data = 32'h0000_0006;
      golden[2] = make_rec(evs[2], 1);
      golden[2][REC_DATA_LSB +: 32] = 32'h0000_0005;
      for (int i = 0; i < 3; i++) begin
         send_event(evs[i]);
         tick(6);
      end
      checks++;
      if (mis_a !== 1'b1 || fidx_a !== 6'd2 || fpc_a !== evs[2].pc || match_a !== 32'd2) begin
         errors++;
         $display("FAIL data_mismatch: got mis=%b idx=%0d pc=%h cnt=%0d, required mis=1 idx=2 pc=%h cnt=2",
                  mis_a, fidx_a, fpc_a, match_a, evs[2].pc);
      end
      send_event(evs[3]);
      for (int i = 0; i < 10; i++) begin
         saw_req = saw_req | req_a;
         tick(1);
      end
      checks++;
      if (saw_req !== 1'b0 || state_a !== S_HALT) begin
         errors++;
         $display("FAIL halt_no_req: got req_seen=%b state=%0d, required 0 and %0d",
                  saw_req, state_a, S_HALT);
      end
   endtask

   task automatic test_x0_write();
      do_reset();
      evs[0] = rand_event(0);
      evs[0].data = 32'hDEAD_BEEF;
      golden[0] = pack_rec(evs[0].pc, evs[0].instr, 32'h0000_1234, evs[0].mem_addr,
                           5'd7, 2'd0, evs[0].is_load);
      evs[1] = rand_event(1);
      golden[1] = pack_rec(evs[1].pc, evs[1].instr, evs[1].data, evs[1].mem_addr,
                           evs[1].rd, 2'd0, evs[1].is_load);
      send_event(evs[0]);
      tick(6);
      checks++;
      if (match_a !== 32'd1 || mis_a !== 1'b0) begin
         errors++;
         $display("FAIL x0_write: got cnt=%0d mis=%b, required cnt=1 mis=0", match_a, mis_a);
      end
      send_event(evs[1]);
      tick(6);
      checks++;
      if (mis_a !== 1'b1 || fidx_a !== 6'd1) begin
         errors++;
         $display("FAIL nonzero_rd_kind0: got mis=%b idx=%0d, required mis=1 idx=1", mis_a, fidx_a);
      end
   endtask

   task automatic test_overflow();
      int cls [12];
      int acc [$];
      int occ = 0, next_pop = -1, svc;
      logic pop, push;
      do_reset();
      ack_delay = 2;
      svc = 3 + ack_delay;
      // Service model: each record occupies the checker for 3 + ack delay
      // cycles, and a full buffer loses any event that arrives while
      // nothing leaves.
      for (int t = 0; t < 12; t++) begin
         cls[t] = $urandom_range(0, 3);
         evs[t] = rand_event(cls[t]);
         pop  = (t == next_pop);
         push = (occ < 8) || pop;
         if (push) acc.push_back(t);
         occ = occ + int'(push) - int'(pop);
         if (pop || (push && occ == 1)) next_pop = (occ > 0) ? t + svc : -1;
      end
      foreach (acc[k]) golden[k] = make_rec(evs[acc[k]], cls[acc[k]]);
      for (int t = 0; t < 12; t++) begin
         put_event(evs[t]);
         @(negedge clk);
      end
      valid = 1'b0;
      tick(80);
      checks++;
      if (ovf_a !== 1'b1) begin
         errors++;
         $display("FAIL overflow_flag: got %b, required 1", ovf_a);
      end
      checks++;
      if (match_a !== 32'(acc.size()) || mis_a !== 1'b0) begin
         errors++;
         $display("FAIL overflow_dropped: got cnt=%0d mis=%b, required cnt=%0d mis=0",
                  match_a, mis_a, acc.size());
      end
   endtask

   task automatic test_random(input int n);
      int first_bad = -1, exp_matches = 0, cls, b;
      logic [REC_W-1:0] g;
      do_reset();
      for (int i = 0; i < n; i++) begin
         cls = $urandom_range(0, 3);
         evs[i] = rand_event(cls);
         g = make_rec(evs[i], cls);
         if ($urandom_range(0, 5) == 0) begin
            b = $urandom_range(0, REC_W - 1);
            g[b] = ~g[b];
         end
         golden[i] = g;
         if (first_bad < 0) begin
            if (ref_match(g, evs[i])) exp_matches++;
            else first_bad = i;
         end
      end
      for (int i = 0; i < n; i++) begin
         ack_delay = $urandom_range(0, 3);
         send_event(evs[i]);
         tick(8);
      end
      checks++;
      if (match_a !== 32'(exp_matches) || mis_a !== (first_bad >= 0) || ovf_a !== 1'b0) begin
         errors++;
         $display("FAIL random_counts: got cnt=%0d mis=%b ovf=%b, required cnt=%0d mis=%b ovf=0",
                  match_a, mis_a, ovf_a, exp_matches, first_bad >= 0);
      end
      if (first_bad >= 0) begin
         checks++;
         if (fidx_a !== 6'(first_bad) || fpc_a !== evs[first_bad].pc) begin
            errors++;
            $display("FAIL random_fail_info: got idx=%0d pc=%h, required idx=%0d pc=%h",
                     fidx_a, fpc_a, first_bad, evs[first_bad].pc);
         end
      end
   endtask

   task automatic test_done();
      int cls;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cls = $urandom_range(0, 3);
         evs[i] = rand_event(cls);
         golden[i] = make_rec(evs[i], cls);
      end
      for (int i = 0; i < 4; i++) begin
         send_event(evs[i]);
         tick(6);
         if (i == 2) begin
            checks++;
            if (done_b !== 1'b0) begin
               errors++;
               $display("FAIL done_early: got %b after 3 checks, required 0", done_b);
            end
         end
      end
      checks++;
      if (done_b !== 1'b1 || match_b !== 32'd4 || extra_b !== 1'b0 || state_b !== S_DONE) begin
         errors++;
         $display("FAIL done_after_4: got done=%b cnt=%0d extra=%b state=%0d, required 1 4 0 %0d",
                  done_b, match_b, extra_b, state_b, S_DONE);
      end
      send_event(evs[4]);
      tick(4);
      checks++;
      if (extra_b !== 1'b1 || match_b !== 32'd4 || req_b !== 1'b0) begin
         errors++;
         $display("FAIL extra_retire: got extra=%b cnt=%0d req=%b, required 1 4 0",
                  extra_b, match_b, req_b);
      end
   endtask

   task automatic test_done_priority();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         evs[i] = rand_event(2);
         golden[i] = make_rec(evs[i], 2);
      end
      golden[3][REC_PC_LSB] = ~golden[3][REC_PC_LSB];
      for (int i = 0; i < 4; i++) begin
         send_event(evs[i]);
         tick(6);
      end
      checks++;
      if (done_b !== 1'b1 || state_b !== S_DONE || mis_b !== 1'b1 || fidx_b !== 2'd3
          || match_b !== 32'd3) begin
         errors++;
         $display("FAIL done_over_halt: got done=%b state=%0d mis=%b idx=%0d cnt=%0d, required 1 %0d 1 3 3",
                  done_b, state_b, mis_b, fidx_b, match_b, S_DONE);
      end
   endtask

   task automatic test_reset_in_fetch();
      logic busy = 1'b0;
      do_reset();
      evs[0] = rand_event(1);
      golden[0] = make_rec(evs[0], 1);
      send_event(evs[0]);
      tick(5);
      ack_delay = 50;
      evs[1] = rand_event(3);
      golden[1] = make_rec(evs[1], 3);
      send_event(evs[1]);
      tick(2);
      checks++;
      if (req_a !== 1'b1 || state_a !== S_FETCH || match_a !== 32'd1) begin
         errors++;
         $display("FAIL fetch_pending: got req=%b state=%0d cnt=%0d, required 1 %0d 1",
                  req_a, state_a, match_a, S_FETCH);
      end
      reset = 1'b1;
      tick(1);
      checks++;
      if (req_a !== 1'b0 || match_a !== 32'd0 || state_a !== S_IDLE) begin
         errors++;
         $display("FAIL reset_in_fetch: got req=%b cnt=%0d state=%0d, required 0 0 %0d",
                  req_a, match_a, state_a, S_IDLE);
      end
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         busy = busy | req_a | (state_a !== S_IDLE);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL fifo_flushed: got activity=%b after reset, required 0", busy);
      end
      ack_delay = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic_match();
      test_data_mismatch();
      test_x0_write();
      test_overflow();
      for (int r = 0; r < 3; r++) test_random(24);
      test_done();
      test_done_priority();
      test_reset_in_fetch();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/trace_checker.md
TRACE_CHECKER -- requirements
Module: trace_checker

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: retire-event buffer entries, power of two, at least 2.
REQ-002 SHALL have parameter TRACE_LEN, default 1024: number of golden records to check.
REQ-003 SHALL have parameter STOP_ON_MISMATCH, default 1: when 1, checking halts at the first mismatch.
REQ-004 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_i, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port valid_i, input, 1: retire strobe, one cycle high per retired instruction.
REQ-007 SHALL have ports pc_i and instr_i, inputs, 32 each: retired PC and instruction word.
REQ-008 SHALL have port reg_addr_i, input, 5: destination register index.
REQ-009 SHALL have port reg_data_i, input, 32: destination write data.
REQ-010 SHALL have ports is_load_i, is_store_i and is_float_i, inputs, 1 each: retire qualifiers.
REQ-011 SHALL have ports mem_addr_i and mem_data_i, inputs, 32 each: memory access address and store data.
REQ-012 SHALL have ports exp_req_o (output, 1) and exp_idx_o (output, clog2(TRACE_LEN)): golden-record read request and record index.
REQ-013 SHALL have ports exp_ack_i (input, 1) and exp_rec_i (input, 136): read acknowledge and packed golden record, valid while exp_ack_i is high.
REQ-014 SHALL have outputs match_cnt_o (32), done_o (1), mismatch_o (1), overflow_o (1), extra_o (1), fail_idx_o (clog2(TRACE_LEN)), fail_pc_o (32).

Function
REQ-015 SHALL push one event {pc, instr, rd, data, mem_addr, mem_data, is_load, is_store, is_float} into the FIFO each cycle valid_i is high and the FIFO is not full.
REQ-016 SHALL drop the event and set sticky overflow_o when valid_i is high and the FIFO is full with no pop in the same cycle; a simultaneous pop and push on a full FIFO SHALL accept the push.
REQ-017 SHALL implement the FSM IDLE -> FETCH -> CMP -> IDLE, plus terminal states DONE and HALT.
REQ-018 SHALL, in IDLE, move to FETCH when the FIFO is non-empty and fewer than TRACE_LEN records have been checked.
REQ-019 SHALL, in FETCH, hold exp_req_o high and exp_idx_o equal to the check index until exp_ack_i; on the ack cycle it SHALL capture exp_rec_i and go to CMP.
REQ-020 SHALL, in CMP (one cycle), compare the FIFO head against the captured record, pop the FIFO, and increment the check index.
REQ-021 SHALL use golden record fields: pc[31:0], instr[31:0], data[31:0], mem_addr[31:0], rd[4:0], kind[1:0] (0 none, 1 int, 2 float, 3 store), load[0], packed MSB-first in that order.
REQ-022 SHALL always compare pc and instr.
REQ-023 SHALL compare mem_addr and data against mem_data when kind=3.
REQ-024 SHALL compare rd and data when kind is 1 or 2, and SHALL require is_float = (kind==2).
REQ-025 SHALL additionally compare mem_addr when kind is 1 or 2 and load=1.
REQ-026 SHALL treat kind=0 as a match only if the event has is_store=0 and, for an int write, rd=0.
REQ-027 SHALL require is_store_i = (kind==3) and is_load_i = load in every case.
REQ-028 SHALL, on a match, increment match_cnt_o, saturating at 0xFFFFFFFF.
REQ-029 SHALL, on the first mismatch, set sticky mismatch_o and latch fail_idx_o and fail_pc_o (event PC); later mismatches SHALL NOT overwrite them.
REQ-030 SHALL, after a mismatch, go to HALT if STOP_ON_MISMATCH=1, otherwise return to IDLE.
REQ-031 SHALL, after the check of record TRACE_LEN-1, enter DONE and raise done_o; this SHALL take priority over HALT.
REQ-032 SHALL, in DONE or HALT, drain the FIFO one entry per cycle without comparing and issue no requests.
REQ-033 SHALL, in DONE, set sticky extra_o on any valid_i.
REQ-034 SHALL give a minimum per-record latency of 3 cycles from FIFO non-empty to the match_cnt_o update (IDLE, FETCH with same-cycle ack, CMP).

Reset
REQ-035 SHALL, while reset_i is high at a clock edge, enter IDLE, empty the FIFO, zero the check index and all outputs, and deassert exp_req_o.
REQ-036 SHALL abandon any outstanding request on reset, and SHALL ignore an exp_ack_i arriving after reset.

Structure
REQ-037 SHALL place the record width (136), field offsets, kind encodings, the event struct and the FSM state enum in a shared package, trace_pkg.
REQ-038 SHALL implement the buffer as one sub-module, trace_fifo: synchronous, first-word fall-through, with full/empty flags.

Verification
REQ-039 SHALL cover 3 spaced retires matching golden records with exp_ack_i the same cycle -> match_cnt_o=3, mismatch_o=0.
REQ-040 SHALL cover record 2 having data 0x0000_0005 while the event carries 0x0000_0006 -> mismatch_o=1, fail_idx_o=2, fail_pc_o=event PC, exp_req_o stays low afterwards (STOP_ON_MISMATCH=1).
REQ-041 SHALL cover an x0 write (rd=0) against a kind=0 record -> match, even though reg_data_i differs.
REQ-042 SHALL cover 12 back-to-back valid_i pulses with exp_ack_i delayed 2 cycles, FIFO_DEPTH=8 -> overflow_o=1 and the dropped events are never checked.
REQ-043 SHALL cover TRACE_LEN=4 with 5 retires -> done_o=1 after the 4th check, then extra_o=1.
REQ-044 SHALL cover reset_i asserted during FETCH -> next cycle exp_req_o=0, match_cnt_o=0, FIFO empty.
